// File: rtl/rotate_amount_finder.sv
// rotate_amount_finder: sequential search for the smallest left-rotate amount mapping data onto target.
// Define ROT_FIND_FIXED_LAT_EN for constant 32-candidate latency regardless of data.
module rotate_amount_finder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic [31:0] target_in,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [4:0]  amount_left,
  output logic [4:0]  amount_right
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [31:0] cur_q, cur_d, tgt_q, tgt_d;
  logic [4:0]  k_q, k_d, left_q, left_d, right_q, right_d;
  logic        found_q, found_d, hit;
  assign hit = cur_q == tgt_q;
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    k_d     = k_q;
    found_d = found_q;
    left_d  = left_q;
    right_d = right_q;
    if (state_q == IDLE) begin
      if (start) begin
        cur_d   = data_in;
        tgt_d   = target_in;
        k_d     = 5'd0;
        found_d = 1'b0;
        left_d  = 5'd0;
        right_d = 5'd0;
        state_d = SEARCH;
      end
    end else if (state_q == SEARCH) begin
`ifdef ROT_FIND_FIXED_LAT_EN
      // found_q doubles as the "already captured" flag so later matches never overwrite the smallest k
      if (hit && !found_q) begin
        found_d = 1'b1;
        left_d  = k_q;
        right_d = ~k_q + 5'd1;
      end
      if (k_q == 5'd31) state_d = DONE;
      else begin
        cur_d = {cur_q[30:0], cur_q[31]};
        k_d   = k_q + 5'd1;
      end
`else
      if (hit) begin
        found_d = 1'b1;
        left_d  = k_q;
        right_d = ~k_q + 5'd1;
        state_d = DONE;
      end else if (k_q == 5'd31) begin
        found_d = 1'b0;
        left_d  = 5'd0;
        right_d = 5'd0;
        state_d = DONE;
      end else begin
        cur_d = {cur_q[30:0], cur_q[31]};
        k_d   = k_q + 5'd1;
      end
`endif
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      k_q     <= '0;
      found_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      k_q     <= k_d;
      found_q <= found_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end
  assign busy         = state_q == SEARCH;
  assign done         = state_q == DONE;
  assign found        = found_q;
  assign amount_left  = left_q;
  assign amount_right = right_q;
endmodule

// File: doc/rotate_amount_finder.md
# rotate_amount_finder

Sequential inverse of the counters-library 32-bit rotator. Given an original word and a rotated word, it searches rotation amounts one per clock and reports the smallest left-rotate amount that maps the original onto the target, with the equivalent right-rotate amount. It sits beside the combinational rotator and is used to recover or check the shift/direction pair applied to a word.

## Interface
Parameters: none (width fixed at 32, amount width fixed at 5).
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a search; accepted only when busy=0
- data_in  input  32  original word, sampled on accepted start
- target_in  input  32  rotated word, sampled on accepted start
- busy  output  1  high from the edge after accepted start until done
- done  output  1  one-cycle pulse: result valid
- found  output  1  1 = some k in 0..31 satisfies rotl(data,k)==target
- amount_left  output  5  smallest such k (0 if not found)
- amount_right  output  5  (32-k) mod 32, equivalent right-rotate amount (0 if not found)

## Operation
- FSM states: IDLE, SEARCH, DONE.
- IDLE: on start=1, latch data_in into cur, target_in into tgt, k<=0, clear found/amount_left/amount_right to 0, go SEARCH.
- SEARCH, each cycle: if cur==tgt → record found=1, amount_left=k, amount_right=(~k)+1 (5-bit wrap), go DONE. Else if k==31 → found=0, amounts 0, go DONE. Else cur<=rotl(cur,1), k<=k+1.
- DONE: done=1 for exactly this cycle, then IDLE unconditionally.
- busy = (state==SEARCH); done = (state==DONE).
- start while SEARCH or DONE: ignored, no effect on latched operands.
- Results (found, amount_left, amount_right) hold from DONE until the next accepted start.
- Periodic data (e.g. 0xAAAAAAAA): multiple k match; smallest k reported.
- data==target: k=0, found=1, both amounts 0.
- rst (any time, including mid-search): state IDLE; busy, done, found, amount_left, amount_right, k, cur, tgt all 0. Search abandoned, no done pulse.

## Timing
- Start accepted at edge E0; candidate k compared in cycle following edge Ek.
- Match at k: DONE entered at edge E(k+1); done high in cycle after E(k+1); IDLE at E(k+2). Start-to-done latency k+1 edges (min 1, max 32).
- No match: DONE at E32, done high in the cycle after.
- New start may be accepted at the edge where state is IDLE (earliest E(k+2)); back-to-back throughput one search per k+2 cycles.
- All outputs registered/state-decoded; no combinational path from inputs to outputs.

## Configuration
- ROT_FIND_FIXED_LAT_EN defined: SEARCH never exits early; all 32 candidates are evaluated, first match (smallest k) is captured and kept, DONE always entered at E32 regardless of data (constant-time, data-independent latency).
- Not defined: early exit on first match as described above.

## Test plan
- Reset, then data_in=0x80000001, target_in=0x00000003, start pulse → busy for 2 cycles, done at edge E2, found=1, amount_left=1, amount_right=31.
- data_in=0x12345678, target_in=0x81234567 → found=1, amount_left=28, amount_right=4; done after E29 (or E32 with ROT_FIND_FIXED_LAT_EN).
- data_in=0xAAAAAAAA, target_in=0x55555555 → found=1, amount_left=1, amount_right=31 (smallest of many matches); data_in=target_in=0xDEADBEEF → amount_left=0, amount_right=0, done after E1.
- data_in=0x00000001, target_in=0x00000003 → found=0, amounts 0, done after E32; next start with data_in=0x1, target_in=0x80000000 → found=1, left=31, right=1.
- Start search 0x00000001→0x00010000 (k=16); pulse start with different operands at k=5 → ignored, result still left=16, right=16.
- Assert rst at k=10 of a search → all outputs 0 asynchronously, no done pulse; fresh start after release completes normally.
